// File: rtl/divider_checker.sv
// Measures high/low/period of a sys_clk-synchronous divided clock and checks it against DIV_N.
// All results register one cycle after the sampled rising edge; purely observational, no backpressure.
module divider_checker #(
    parameter int DIV_N    = 6,
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             clk_in,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] low_len,
    output logic [CNT_W-1:0] period,
    output logic             meas_valid,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_cnt
);

    localparam int STRK_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]  DIV_N_C = CNT_W'(DIV_N);
    localparam logic [CNT_W-1:0]  HALF_C  = CNT_W'(DIV_N / 2);
    localparam logic [STRK_W-1:0] LOCK_C  = STRK_W'(LOCK_CNT);

    typedef enum logic {IDLE, ARMED} state_t;

    state_t             state_q, state_d;
    logic               clk_d_q;
    logic [CNT_W-1:0]   hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0]   lo_cnt_q, lo_cnt_d;
    logic [STRK_W-1:0]  streak_q, streak_d;
    logic [CNT_W-1:0]   high_len_q, high_len_d;
    logic [CNT_W-1:0]   low_len_q, low_len_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               meas_valid_q, meas_valid_d;
    logic               locked_q, locked_d;
    logic               err_q, err_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic               rise;
    logic               good;

    assign rise = clk_in & ~clk_d_q;
    assign good = ((hi_cnt_q + lo_cnt_q) == DIV_N_C) && (hi_cnt_q == HALF_C);

    always_comb begin
        state_d      = state_q;
        hi_cnt_d     = hi_cnt_q;
        lo_cnt_d     = lo_cnt_q;
        streak_d     = streak_q;
        high_len_d   = high_len_q;
        low_len_d    = low_len_q;
        period_d     = period_q;
        locked_d     = locked_q;
        meas_valid_d = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                // First edge only starts a period; nothing is measured yet.
                if (rise) begin
                    hi_cnt_d = CNT_W'(1);
                    lo_cnt_d = '0;
                    state_d  = ARMED;
                end
            end
            ARMED: begin
                if (rise) begin
                    high_len_d   = hi_cnt_q;
                    low_len_d    = lo_cnt_q;
                    period_d     = hi_cnt_q + lo_cnt_q;
                    meas_valid_d = 1'b1;
                    hi_cnt_d     = CNT_W'(1);
                    lo_cnt_d     = '0;
                    if (good) begin
                        if (streak_q != LOCK_C) streak_d = streak_q + 1'b1;
                        locked_d = (streak_q >= LOCK_C - 1'b1);
                    end else begin
                        err_d    = 1'b1;
                        streak_d = '0;
                        locked_d = 1'b0;
                    end
                end else if ((clk_in && hi_cnt_q == DIV_N_C) ||
                             (!clk_in && lo_cnt_q == DIV_N_C)) begin
                    // A phase already longer than a whole period: stalled clock.
                    err_d    = 1'b1;
                    streak_d = '0;
                    locked_d = 1'b0;
                    hi_cnt_d = '0;
                    lo_cnt_d = '0;
                    state_d  = IDLE;
                end else if (clk_in) begin
                    hi_cnt_d = hi_cnt_q + 1'b1;
                end else begin
                    lo_cnt_d = lo_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            clk_d_q      <= 1'b0;
            hi_cnt_q     <= '0;
            lo_cnt_q     <= '0;
            streak_q     <= '0;
            high_len_q   <= '0;
            low_len_q    <= '0;
            period_q     <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            clk_d_q      <= clk_in;
            hi_cnt_q     <= hi_cnt_d;
            lo_cnt_q     <= lo_cnt_d;
            streak_q     <= streak_d;
            high_len_q   <= high_len_d;
            low_len_q    <= low_len_d;
            period_q     <= period_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign high_len   = high_len_q;
    assign low_len    = low_len_q;
    assign period     = period_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign err        = err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_divider_checker.sv
// Directed bench for divider_checker with DIV_N=6, LOCK_CNT=4.
module tb_divider_checker;

    localparam int DIV_N    = 6;
    localparam int CNT_W    = 8;
    localparam int LOCK_CNT = 4;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n;
    logic             clk_in;
    logic [CNT_W-1:0] high_len, low_len, period;
    logic             meas_valid, locked, err;
    logic [7:0]       err_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int err_pulses  = 0;
    int mv_pulses   = 0;
    logic prev_mv   = 1'b0;
    logic prev_err  = 1'b0;

    // Outputs captured one cycle after the rising edge that opens each period.
    logic             s_mv, s_err, s_lk;
    logic [CNT_W-1:0] s_hl, s_ll, s_pd;
    logic [7:0]       s_ec;

    divider_checker #(.DIV_N(DIV_N), .CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .clk_in     (clk_in),
        .high_len   (high_len),
        .low_len    (low_len),
        .period     (period),
        .meas_valid (meas_valid),
        .locked     (locked),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic v);
        clk_in = v;
        @(posedge sys_clk);
        #1;
        if (prev_mv)  chk("mv_single_cycle", 32'(meas_valid), 0);
        if (prev_err) chk("err_single_cycle", 32'(err), 0);
        if (meas_valid) mv_pulses++;
        if (err)        err_pulses++;
        prev_mv  = meas_valid;
        prev_err = err;
    endtask

    task automatic per(input int hi, input int lo);
        cyc(1'b1);
        s_mv = meas_valid; s_err = err; s_lk = locked;
        s_hl = high_len;   s_ll = low_len; s_pd = period; s_ec = err_cnt;
        for (int i = 1; i < hi; i++) cyc(1'b1);
        for (int i = 0; i < lo; i++) cyc(1'b0);
    endtask

    task automatic chk_meas(input string tag, input int hl, input int ll, input int pd,
                            input int er, input int lk);
        chk({tag, "_mv"},     32'(s_mv), 1);
        chk({tag, "_high"},   32'(s_hl), hl);
        chk({tag, "_low"},    32'(s_ll), ll);
        chk({tag, "_period"}, 32'(s_pd), pd);
        chk({tag, "_err"},    32'(s_err), er);
        chk({tag, "_locked"}, 32'(s_lk), lk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_high"},    32'(high_len), 0);
        chk({tag, "_low"},     32'(low_len), 0);
        chk({tag, "_period"},  32'(period), 0);
        chk({tag, "_mv"},      32'(meas_valid), 0);
        chk({tag, "_locked"},  32'(locked), 0);
        chk({tag, "_err"},     32'(err), 0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
    endtask

    // clk_in low from reset, then ideal /6 until lock.
    task automatic acquire(input string tag);
        err_pulses = 0;
        mv_pulses  = 0;
        repeat (10) cyc(1'b0);
        chk({tag, "_stuck_low_err"}, 32'(err_pulses), 0);
        per(3, 3);
        chk({tag, "_first_rise_mv"}, 32'(s_mv), 0);
        per(3, 3);
        chk_meas({tag, "_m1"}, 3, 3, 6, 0, 0);
        per(3, 3);
        chk_meas({tag, "_m2"}, 3, 3, 6, 0, 0);
        per(3, 3);
        chk_meas({tag, "_m3"}, 3, 3, 6, 0, 0);
        per(3, 3);
        chk_meas({tag, "_m4"}, 3, 3, 6, 0, 1);
        chk({tag, "_err_pulses"}, 32'(err_pulses), 0);
        chk({tag, "_mv_pulses"},  32'(mv_pulses), 4);
        chk({tag, "_err_cnt"},    32'(s_ec), 0);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        clk_in    = 1'b0;
        cyc(1'b0);
        sys_rst_n = 1'b1;
        chk_zero("reset");

        acquire("acq1");

        // One 4/2 period while locked.
        per(4, 2);
        per(3, 3);
        chk_meas("bad42", 4, 2, 6, 1, 0);
        chk("bad42_err_cnt", 32'(s_ec), 1);
        repeat (3) per(3, 3);
        chk("relock1_not_yet", 32'(s_lk), 0);
        per(3, 3);
        chk("relock1_locked", 32'(s_lk), 1);

        // One 4/4 period.
        per(4, 4);
        per(3, 3);
        chk_meas("bad44", 4, 4, 8, 1, 0);
        chk("bad44_err_cnt", 32'(s_ec), 2);
        repeat (4) per(3, 3);
        chk("relock2_locked", 32'(s_lk), 1);
        chk("relock2_err_cnt", 32'(s_ec), 2);

        // Reset while locked discards everything.
        sys_rst_n = 1'b0;
        cyc(1'b0);
        sys_rst_n = 1'b1;
        chk_zero("rst_mid");
        acquire("acq2");

        // Stuck high after a rising edge.
        cyc(1'b1);
        chk("stall_rise_mv", 32'(meas_valid), 1);
        err_pulses = 0;
        mv_pulses  = 0;
        repeat (5) cyc(1'b1);
        chk("stall_early_err", 32'(err_pulses), 0);
        cyc(1'b1);
        chk("stall_err",     32'(err), 1);
        chk("stall_mv",      32'(meas_valid), 0);
        chk("stall_locked",  32'(locked), 0);
        chk("stall_err_cnt", 32'(err_cnt), 1);
        repeat (5) cyc(1'b1);
        repeat (8) cyc(1'b0);
        chk("stall_err_once", 32'(err_pulses), 1);
        chk("stall_no_mv",    32'(mv_pulses), 0);
        per(3, 3);
        chk("rearm_rise_mv", 32'(s_mv), 0);
        per(3, 3);
        chk_meas("rearm", 3, 3, 6, 0, 0);

        // Saturation of the error counter.
        err_pulses = 0;
        repeat (300) per(4, 2);
        per(3, 3);
        chk("sat_last_err",   32'(s_err), 1);
        chk("sat_err_pulses", 32'(err_pulses), 300);
        chk("sat_err_cnt",    32'(err_cnt), 255);
        chk("sat_locked",     32'(locked), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/divider_checker.md
Name: divider_checker

Overview:
- Monitors a divided clock produced in the `sys_clk` domain, such as the output of an even-ratio clock divider.
- Measures high time, low time and period in `sys_clk` cycles and checks them against the expected ratio `DIV_N`.
- Reports per-period measurements, a lock indication, error pulses and a saturating error count.
- Sits downstream of the divider; serves as a built-in self-check and as a reusable bench monitor.

Parameters:
- `DIV_N`, 6: expected division ratio; must be even and ≥2; expected high = low = `DIV_N`/2.
- `CNT_W`, 8: width of the length/period outputs; must hold 2*`DIV_N`.
- `LOCK_CNT`, 4: number of consecutive good periods required to assert `locked`.

Ports:
- `sys_clk`, input, 1: system clock; all logic on its rising edge.
- `sys_rst_n`, input, 1: reset, synchronous, active-low.
- `clk_in`, input, 1: divided clock under test, synchronous to `sys_clk`.
- `high_len`, output, `CNT_W`: high samples in the last complete period.
- `low_len`, output, `CNT_W`: low samples in the last complete period.
- `period`, output, `CNT_W`: `high_len` + `low_len` of the last complete period.
- `meas_valid`, output, 1: one-cycle pulse; new `high_len`/`low_len`/`period` are valid.
- `locked`, output, 1: `LOCK_CNT` consecutive good periods seen, no error since.
- `err`, output, 1: one-cycle pulse on a bad period or a stall.
- `err_cnt`, output, 8: number of `err` pulses, saturating at 255.

Behaviour:
- Reset is synchronous: `sys_rst_n`=0 sampled at a `sys_clk` edge.
  - All outputs go to 0.
  - `clk_d`, counters and streak go to 0; state goes to IDLE.
  - Reset mid-operation discards any partial period.
- Edge detect: `clk_d` <= `clk_in` every cycle. Rising edge `rise` = `clk_in` & ~`clk_d`.
- IDLE state:
  - No counting.
  - On `rise`: set `hi_cnt`=1, `lo_cnt`=0, go to ARMED. No `meas_valid` is produced.
- ARMED state, per cycle, in priority order:
  - On `rise`:
    - Register `high_len`<=`hi_cnt`, `low_len`<=`lo_cnt`, `period`<=`hi_cnt`+`lo_cnt`.
    - Pulse `meas_valid`=1 in the next cycle.
    - Then `hi_cnt`<=1, `lo_cnt`<=0.
  - Else if `clk_in`=1 and `hi_cnt`==`DIV_N`, or `clk_in`=0 and `lo_cnt`==`DIV_N`: stall.
    - Pulse `err` next cycle; `locked`<=0; streak<=0.
    - `meas_valid` stays 0; `hi_cnt` and `lo_cnt` cleared; go to IDLE.
  - Else increment `hi_cnt` if `clk_in`=1, or `lo_cnt` if `clk_in`=0.
  - Counters never exceed `DIV_N`, so no wrap is possible.
- Latency: the outputs, `meas_valid`, `err` and `locked` update 1 cycle after the sampled rising edge and are mutually coherent.
- Check on each measurement:
  - Good period: `period`==`DIV_N` and `high_len`==`DIV_N`/2.
  - Good: streak <= min(streak+1, `LOCK_CNT`); `locked`<=1 when streak+1 ≥ `LOCK_CNT`.
  - Bad: `err` pulses in the same cycle as `meas_valid`; streak<=0; `locked`<=0.
- `err_cnt` increments on every `err` pulse and holds at 255.
- `meas_valid` and `err` are never high for two consecutive cycles. Back-to-back periods (minimum `DIV_N`=2) still yield pulses separated by ≥1 low cycle.
- `clk_in` stuck low from reset: the block stays in IDLE indefinitely, with no `err`. Stuck detection requires a first rising edge.

Test Plan (`DIV_N`=6, `LOCK_CNT`=4):
- Reset 1 cycle, then ideal /6 divider (3 high, 3 low) -> first `meas_valid` 1 cycle after the 2nd rising edge with `high_len`=3, `low_len`=3, `period`=6; `locked`=1 together with the 4th `meas_valid`; `err` never asserted.
- While locked, inject one period of 4 high / 2 low -> `meas_valid` with 4/2/6, `err` pulse the same cycle, `locked`=0, `err_cnt`=1; 4 further good periods re-lock.
- Inject a 4 high / 4 low period -> 4/4/8, `err`=1, `locked`=0.
- Hold `clk_in`=1 after a rising edge -> `err` pulse exactly once, 1 cycle after the 7th consecutive high sample; no `meas_valid`; state IDLE; the next rising edge re-arms, and the first `meas_valid` comes only after the following rising edge.
- Assert `sys_rst_n`=0 for 1 cycle while locked with `err_cnt`=2 -> all outputs 0 after that edge; re-acquisition matches the first scenario.
- Force 300 bad periods -> `err_cnt` saturates at 255, and `err` keeps pulsing once per bad period.
